// File: rtl/ex_stage_sequencer.sv
// rtl/ex_stage_sequencer.sv - execute-stage sequencer: decode handshake, multi-cycle hold, result register, redirect pulse
module ex_stage_sequencer #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic             in_multicycle,
    input  logic             flush,
    output logic             ex_enable,
    input  logic             ex_done,
    input  logic             ex_jump,
    input  logic [63:0]      ex_target,
    input  logic [63:0]      ex_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [63:0]      out_pc,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MC_W = $clog2(MC_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_MC, HOLD} state_e;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             mc_q, mc_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [63:0]      out_result_q, out_result_d;
    logic [63:0]      out_pc_q, out_pc_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [63:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept;
    logic             capture;

    // A pending redirect blocks acceptance so no wrong-path op slips in.
    assign in_ready  = ((state_q == IDLE) || ((state_q == HOLD) && out_ready))
                       && !redirect_valid_q && !flush;
    assign accept    = in_valid && in_ready;
    assign ex_enable = (state_q == EXEC) || (state_q == WAIT_MC);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    assign out_result     = out_result_q;
    assign out_pc         = out_pc_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_cycles   = stall_q;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        mc_d             = mc_q;
        mc_cnt_d         = mc_cnt_q;
        out_result_d     = out_result_q;
        out_pc_d         = out_pc_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        stall_d          = stall_q;
        capture          = 1'b0;

        if (flush) begin
            state_d  = IDLE;
            mc_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        pc_d    = in_pc;
                        mc_d    = in_multicycle;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (mc_q) begin
                        mc_cnt_d = MC_W'(MC_LATENCY - 2);
                        state_d  = WAIT_MC;
                    end else if (ex_done) begin
                        capture = 1'b1;
                    end else begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end
                WAIT_MC: begin
                    if (mc_cnt_q != '0) begin
                        mc_cnt_d = mc_cnt_q - MC_W'(1);
                    end else if (ex_done) begin
                        capture = 1'b1;
                    end else begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!out_ready) begin
                        stall_d = stall_q + CNT_W'(1);
                    end else if (accept) begin
                        pc_d    = in_pc;
                        mc_d    = in_multicycle;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (capture) begin
            out_result_d = ex_result;
            out_pc_d     = pc_q;
            state_d      = HOLD;
            if (ex_jump) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            pc_q             <= '0;
            mc_q             <= 1'b0;
            mc_cnt_q         <= '0;
            out_result_q     <= '0;
            out_pc_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_q          <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            mc_q             <= mc_d;
            mc_cnt_q         <= mc_cnt_d;
            out_result_q     <= out_result_d;
            out_pc_q         <= out_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_q          <= stall_d;
        end
    end

endmodule
